// File: rtl/hex_scan_disp_if.sv
// Valid/ready word handshake from the FIFO drain path into the display scanner.
interface hex_scan_disp_if #(
    parameter int unsigned DATA_W = 16
);
    logic [DATA_W-1:0] din;
    logic              din_valid;
    logic              din_ready;

    modport master (output din, output din_valid, input  din_ready);
    modport slave  (input  din, input  din_valid, output din_ready);
endinterface

// File: rtl/hex_scan_disp.sv
// Multiplexed hex 7-segment scanner that paces upstream pops by full scan frames.
// Optional build macro HEX_SCAN_LEADING_ZERO_BLANK_EN blanks digits above the top non-zero nibble.
module hex_scan_disp #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned HOLD_FRAMES = 4,
    parameter int unsigned SEG_POL     = 1,
    parameter int unsigned DIG_POL     = 0
) (
    input  logic              clk,
    input  logic              rst,
    hex_scan_disp_if.slave    bus,
    output logic [7:0]        seg,
    output logic [DIGITS-1:0] dig,
    output logic              frame_tick
);
    localparam int unsigned PRE_W = $clog2(REFRESH_DIV);
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned FC_W  = $clog2(HOLD_FRAMES + 1);
    localparam logic [7:0]        SEG_OFF = (SEG_POL != 0) ? 8'h00 : 8'hFF;
    localparam logic [DIGITS-1:0] DIG_OFF = {DIGITS{1'(DIG_POL == 0)}};
    localparam logic [DIGITS-1:0] DIG_ONE = DIGITS'(1);

    typedef enum logic [1:0] {S_EMPTY, S_SHOW, S_READY} state_t;

    state_t            state;
    logic [PRE_W-1:0]  presc;
    logic [IDX_W-1:0]  idx;
    logic [FC_W-1:0]   fcnt;
    logic [DATA_W-1:0] hold;

    logic              tc_c;
    logic              last_c;
    logic              xfer_c;
    logic              blank_c;
    logic [3:0]        nib_c;
    logic [7:0]        seg_on_c;
    logic [DIGITS-1:0] dig_on_c;
    logic [3:0]        nibs [DIGITS];

    function automatic logic [7:0] hex7(input logic [3:0] n);
        logic [7:0] s;
        unique case (n)
            4'h0: s = 8'h3F;  4'h1: s = 8'h06;  4'h2: s = 8'h5B;  4'h3: s = 8'h4F;
            4'h4: s = 8'h66;  4'h5: s = 8'h6D;  4'h6: s = 8'h7D;  4'h7: s = 8'h07;
            4'h8: s = 8'h7F;  4'h9: s = 8'h6F;  4'hA: s = 8'h77;  4'hB: s = 8'h7C;
            4'hC: s = 8'h39;  4'hD: s = 8'h5E;  4'hE: s = 8'h79;  4'hF: s = 8'h71;
        endcase
        return s;
    endfunction

    for (genvar g = 0; g < DIGITS; g++) begin : g_nib
        assign nibs[g] = hold[4*g +: 4];
    end

    assign tc_c   = (presc == PRE_W'(REFRESH_DIV - 1));
    assign last_c = (idx == IDX_W'(DIGITS - 1));
    assign xfer_c = bus.din_valid & bus.din_ready;
    assign nib_c  = nibs[idx];

    // Active-level segment and digit patterns for the current slot.
    always_comb begin
        seg_on_c = (SEG_POL != 0) ? hex7(nib_c) : ~hex7(nib_c);
        dig_on_c = (DIG_POL != 0) ? (DIG_ONE << idx) : ~(DIG_ONE << idx);
    end

`ifdef HEX_SCAN_LEADING_ZERO_BLANK_EN
    logic [IDX_W-1:0] msd_c;

    // Digit 0 is never blanked, so an all-zero word still shows one "0".
    always_comb begin
        msd_c = '0;
        for (int unsigned i = 1; i < DIGITS; i++) begin
            if (hold[4*i +: 4] != 4'h0) msd_c = IDX_W'(i);
        end
    end
    assign blank_c = (idx > msd_c);
`else
    assign blank_c = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_EMPTY;
            presc         <= '0;
            idx           <= '0;
            fcnt          <= '0;
            hold          <= '0;
            frame_tick    <= 1'b0;
            bus.din_ready <= 1'b0;
            seg           <= SEG_OFF;
            dig           <= DIG_OFF;
        end else begin
            presc      <= tc_c ? '0 : presc + 1'b1;
            frame_tick <= tc_c & last_c;
            if (tc_c) idx <= last_c ? '0 : idx + 1'b1;
            if (xfer_c) hold <= bus.din;

            // Ready mirrors "next state is not SHOW"; a load always wins over a frame tick.
            unique case (state)
                S_EMPTY, S_READY: begin
                    if (xfer_c) begin
                        state         <= S_SHOW;
                        fcnt          <= '0;
                        bus.din_ready <= 1'b0;
                    end else begin
                        bus.din_ready <= 1'b1;
                    end
                end
                S_SHOW: begin
                    if (frame_tick) begin
                        fcnt <= fcnt + 1'b1;
                        if (fcnt == FC_W'(HOLD_FRAMES - 1)) begin
                            state         <= S_READY;
                            bus.din_ready <= 1'b1;
                        end
                    end
                end
                default: begin
                    state         <= S_EMPTY;
                    bus.din_ready <= 1'b0;
                end
            endcase

            if (state == S_EMPTY) begin
                seg <= SEG_OFF;
                dig <= DIG_OFF;
            end else begin
                seg <= seg_on_c;
                dig <= blank_c ? DIG_OFF : dig_on_c;
            end
        end
    end
endmodule
